// File: rtl/hazard_ctrl_if.sv
// Pipeline hazard-control bus: stage icodes, register IDs and status
// flowing into the controller, stall/bubble/status and counters out.
// master = pipeline side (drives hazard inputs), slave = hazard_ctrl.
interface hazard_ctrl_if #(
  parameter int REG_W = 4,
  parameter int NSRC  = 2,
  parameter int CNT_W = 16
);
  logic [3:0]            D_icode;
  logic [NSRC*REG_W-1:0] d_src;
  logic [3:0]            E_icode;
  logic [REG_W-1:0]      E_destM;
  logic                  e_Cnd;
  logic [3:0]            M_icode;
  logic [3:0]            m_stat;
  logic [3:0]            W_stat;
  logic                  clr_cnt;
  logic                  setcc;
  logic                  F_stall;
  logic                  D_stall;
  logic                  W_stall;
  logic                  D_bubble;
  logic                  E_bubble;
  logic                  M_bubble;
  logic                  halted;
  logic [1:0]            state;
  logic [CNT_W-1:0]      cnt_lu;
  logic [CNT_W-1:0]      cnt_ret;
  logic [CNT_W-1:0]      cnt_mp;

  modport master (
    output D_icode, d_src, E_icode, E_destM, e_Cnd, M_icode, m_stat, W_stat, clr_cnt,
    input  setcc, F_stall, D_stall, W_stall, D_bubble, E_bubble, M_bubble,
    input  halted, state, cnt_lu, cnt_ret, cnt_mp
  );

  modport slave (
    input  D_icode, d_src, E_icode, E_destM, e_Cnd, M_icode, m_stat, W_stat, clr_cnt,
    output setcc, F_stall, D_stall, W_stall, D_bubble, E_bubble, M_bubble,
    output halted, state, cnt_lu, cnt_ret, cnt_mp
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Y86-style pipeline hazard controller: load-use, ret and mispredict
// stall/bubble generation plus a RUN/DRAIN/HALTED exception FSM.
// Optional event counters are built only when HAZARD_CTRL_PERF_CNT_EN
// is defined; otherwise the counter outputs are tied to zero.
module hazard_ctrl #(
  parameter int REG_W = 4,
  parameter int NSRC  = 2,
  parameter int CNT_W = 16
) (
  input logic          clk,
  input logic          rst_n,
  hazard_ctrl_if.slave hz
);
  localparam logic [REG_W-1:0] RNONE       = {REG_W{1'b1}};
  localparam logic [3:0]       STAT_AOK    = 4'b1000;
  localparam logic [3:0]       IC_NOP0     = 4'h0;
  localparam logic [3:0]       IC_MRMOVQ   = 4'h5;
  localparam logic [3:0]       IC_JXX      = 4'h7;
  localparam logic [3:0]       IC_RET      = 4'h9;
  localparam logic [3:0]       IC_POPQ     = 4'hB;

  typedef enum logic [1:0] {
    ST_RUN    = 2'b00,
    ST_DRAIN  = 2'b01,
    ST_HALTED = 2'b10
  } state_t;

  state_t state_r;

  logic lu_s, ret_s, mp_s, m_bad_s, w_bad_s;
  logic setcc_s, f_stall_s, d_stall_s, w_stall_s;
  logic d_bubble_s, e_bubble_s, m_bubble_s, halted_s;

  // A load in execute whose destination feeds any decode source; RNONE never matches.
  function automatic logic load_use_f(
    input logic [3:0]            icode,
    input logic [REG_W-1:0]      dest,
    input logic [NSRC*REG_W-1:0] srcs
  );
    logic hit;
    hit = 1'b0;
    if ((icode == IC_MRMOVQ || icode == IC_POPQ) && dest != RNONE) begin
      for (int k = 0; k < NSRC; k++) begin
        if (srcs[k*REG_W +: REG_W] == dest) begin
          hit = 1'b1;
        end else begin
          hit = hit;
        end
      end
    end else begin
      hit = 1'b0;
    end
    return hit;
  endfunction

  // Hazard event decode from the current pipeline registers.
  always_comb begin
    lu_s    = load_use_f(hz.E_icode, hz.E_destM, hz.d_src);
    ret_s   = (hz.D_icode == IC_RET) || (hz.E_icode == IC_RET) || (hz.M_icode == IC_RET);
    mp_s    = (hz.E_icode == IC_JXX) && !hz.e_Cnd;
    m_bad_s = (hz.m_stat != STAT_AOK);
    w_bad_s = (hz.W_stat != STAT_AOK);
  end

  // Stall/bubble/setcc selection by FSM state; W_stall follows a bad writeback status everywhere.
  always_comb begin
    setcc_s    = 1'b0;
    f_stall_s  = 1'b0;
    d_stall_s  = 1'b0;
    w_stall_s  = 1'b0;
    d_bubble_s = 1'b0;
    e_bubble_s = 1'b0;
    m_bubble_s = 1'b0;
    halted_s   = 1'b0;
    case (state_r)
      ST_RUN: begin
        f_stall_s  = lu_s | ret_s;
        d_stall_s  = lu_s;
        d_bubble_s = mp_s | (ret_s & ~lu_s);
        e_bubble_s = mp_s | lu_s;
        w_stall_s  = w_bad_s;
        setcc_s    = (hz.E_icode != IC_NOP0) & ~m_bad_s & ~w_bad_s;
      end
      ST_DRAIN: begin
        f_stall_s  = lu_s | ret_s;
        d_stall_s  = lu_s;
        d_bubble_s = mp_s | (ret_s & ~lu_s);
        e_bubble_s = mp_s | lu_s;
        m_bubble_s = 1'b1;
        w_stall_s  = w_bad_s;
      end
      ST_HALTED: begin
        f_stall_s  = 1'b1;
        d_stall_s  = 1'b1;
        w_stall_s  = 1'b1;
        m_bubble_s = 1'b1;
        halted_s   = 1'b1;
      end
      default: begin
        // Unreachable encoding: freeze the pipeline like HALTED.
        f_stall_s  = 1'b1;
        d_stall_s  = 1'b1;
        w_stall_s  = 1'b1;
        m_bubble_s = 1'b1;
        halted_s   = 1'b1;
      end
    endcase
  end

  // Exception FSM: writeback fault halts directly, memory fault drains first; only reset leaves HALTED.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_RUN;
    end else begin
      case (state_r)
        ST_RUN: begin
          if (w_bad_s) begin
            state_r <= ST_HALTED;
          end else if (m_bad_s) begin
            state_r <= ST_DRAIN;
          end else begin
            state_r <= ST_RUN;
          end
        end
        ST_DRAIN: begin
          if (w_bad_s) begin
            state_r <= ST_HALTED;
          end else begin
            state_r <= ST_DRAIN;
          end
        end
        ST_HALTED: state_r <= ST_HALTED;
        default:   state_r <= ST_HALTED;
      endcase
    end
  end

`ifdef HAZARD_CTRL_PERF_CNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] cnt_lu_r, cnt_ret_r, cnt_mp_r;

  // Saturating event counters, active only while running; clear wins over increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_lu_r  <= {CNT_W{1'b0}};
      cnt_ret_r <= {CNT_W{1'b0}};
      cnt_mp_r  <= {CNT_W{1'b0}};
    end else if (hz.clr_cnt) begin
      cnt_lu_r  <= {CNT_W{1'b0}};
      cnt_ret_r <= {CNT_W{1'b0}};
      cnt_mp_r  <= {CNT_W{1'b0}};
    end else if (state_r == ST_RUN) begin
      if (lu_s && cnt_lu_r != CNT_MAX)   cnt_lu_r  <= cnt_lu_r + CNT_ONE;
      if (ret_s && cnt_ret_r != CNT_MAX) cnt_ret_r <= cnt_ret_r + CNT_ONE;
      if (mp_s && cnt_mp_r != CNT_MAX)   cnt_mp_r  <= cnt_mp_r + CNT_ONE;
    end
  end

  assign hz.cnt_lu  = cnt_lu_r;
  assign hz.cnt_ret = cnt_ret_r;
  assign hz.cnt_mp  = cnt_mp_r;
`else
  logic unused_clr_cnt_s;
  assign unused_clr_cnt_s = hz.clr_cnt;
  assign hz.cnt_lu  = {CNT_W{1'b0}};
  assign hz.cnt_ret = {CNT_W{1'b0}};
  assign hz.cnt_mp  = {CNT_W{1'b0}};
`endif

  assign hz.setcc    = setcc_s;
  assign hz.F_stall  = f_stall_s;
  assign hz.D_stall  = d_stall_s;
  assign hz.W_stall  = w_stall_s;
  assign hz.D_bubble = d_bubble_s;
  assign hz.E_bubble = e_bubble_s;
  assign hz.M_bubble = m_bubble_s;
  assign hz.halted   = halted_s;
  assign hz.state    = state_r;
endmodule
